// File: rtl/ax301_peripherals_pkg.sv
// Shared constants and types for the AX301 peripheral-bus blocks.
// Holds the key-input register offsets and the per-key debounce state type.
package ax301_peripherals_pkg;

  localparam int unsigned KEY_REG_LEVEL   = 'h0;
  localparam int unsigned KEY_REG_PRESS   = 'h4;
  localparam int unsigned KEY_REG_RELEASE = 'h8;
  localparam int unsigned KEY_REG_IRQ_EN  = 'hC;

  typedef enum logic {
    STABLE,
    COUNTING
  } ax301_key_state_t;

endpackage

// File: rtl/minibus_slave_if.sv
// Peripheral minibus: single-cycle request, completion and read data one cycle later.
interface minibus_slave_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/ax301_key_debounce.sv
// One board key: 2-FF synchroniser, debounce counter/FSM and press/release pulses.
// Pulses are high in the cycle the debounced level is about to change.
module ax301_key_debounce
  import ax301_peripherals_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic key_n,
  output logic stable,
  output logic press_evt,
  output logic release_evt
);

  localparam int unsigned CntWidth = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync2_q;
  logic                key_s;
  logic                stable_q;
  logic                qualify;
  logic [CntWidth-1:0] cnt_q;
  ax301_key_state_t    state_q;

  assign key_s = ~sync2_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= STABLE;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      unique case (state_q)
        STABLE: begin
          if (key_s != stable_q) begin
            state_q <= COUNTING;
            cnt_q   <= CntWidth'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        COUNTING: begin
          if (key_s == stable_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            stable_q <= key_s;
            state_q  <= STABLE;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Same condition that commits the new level, so the pulse lines up with the change.
  assign qualify     = (state_q == COUNTING) && (key_s != stable_q) && (cnt_q == CntLast);
  assign press_evt   = qualify & key_s;
  assign release_evt = qualify & ~key_s;
  assign stable      = stable_q;

endmodule

// File: rtl/ax301_key_input.sv
// AX301 push-key input block: debounced levels and sticky W1C press/release flags on minibus.
// Define AX301_KEY_IRQ_EN to add the IRQ_EN register and the level irq output.
module ax301_key_input
  import ax301_peripherals_pkg::*;
#(
  parameter int unsigned KEY_COUNT       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  minibus_slave_if.slave       _sif,
  input  logic [KEY_COUNT-1:0] key_n
`ifdef AX301_KEY_IRQ_EN
  ,
  output logic                 irq
`endif
);

  logic [KEY_COUNT-1:0]  level, press_evt, release_evt;
  logic [KEY_COUNT-1:0]  press_q, press_d, release_q, release_d;
  logic [KEY_COUNT-1:0]  press_clr, release_clr;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q;
  logic                  wr_en, rd_en;
  logic                  hit_level, hit_press, hit_release;

  for (genvar i = 0; i < KEY_COUNT; i++) begin : g_key
    ax301_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .nrst       (nrst),
      .key_n      (key_n[i]),
      .stable     (level[i]),
      .press_evt  (press_evt[i]),
      .release_evt(release_evt[i])
    );
  end

  assign wr_en       = _sif.req & _sif.we;
  assign rd_en       = _sif.req & ~_sif.we;
  assign hit_level   = (_sif.addr == ADDR_WIDTH'(KEY_REG_LEVEL));
  assign hit_press   = (_sif.addr == ADDR_WIDTH'(KEY_REG_PRESS));
  assign hit_release = (_sif.addr == ADDR_WIDTH'(KEY_REG_RELEASE));

`ifdef AX301_KEY_IRQ_EN
  logic                 hit_irq_en;
  logic [KEY_COUNT:0]   irq_en_q, irq_en_d;
  logic                 irq_q, irq_d;

  assign hit_irq_en = (_sif.addr == ADDR_WIDTH'(KEY_REG_IRQ_EN));

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_en && hit_irq_en) begin
      irq_en_d = _sif.wdata[KEY_COUNT:0];
    end
    irq_d = (|(press_q & irq_en_q[KEY_COUNT-1:0])) | (irq_en_q[KEY_COUNT] & (|release_q));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  // Set beats a same-cycle clear so no edge is ever lost.
  always_comb begin
    press_clr   = (wr_en && hit_press)   ? _sif.wdata[KEY_COUNT-1:0] : '0;
    release_clr = (wr_en && hit_release) ? _sif.wdata[KEY_COUNT-1:0] : '0;
    press_d     = (press_q & ~press_clr) | press_evt;
    release_d   = (release_q & ~release_clr) | release_evt;

    rdata_d = '0;
    if (rd_en) begin
      if (hit_level) begin
        rdata_d[KEY_COUNT-1:0] = level;
      end else if (hit_press) begin
        rdata_d[KEY_COUNT-1:0] = press_q;
      end else if (hit_release) begin
        rdata_d[KEY_COUNT-1:0] = release_q;
      end
`ifdef AX301_KEY_IRQ_EN
      else if (hit_irq_en) begin
        rdata_d[KEY_COUNT:0] = irq_en_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      press_q   <= '0;
      release_q <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      rdata_q   <= rdata_d;
      ack_q     <= _sif.req;
    end
  end

  assign _sif.rdata = rdata_q;
  assign _sif.ack   = ack_q;

endmodule

// File: tb/tb_ax301_key_input.sv
// Bench for ax301_key_input: directed scenarios plus random key/bus traffic vs a window model.
module tb_ax301_key_input;

  localparam int unsigned KEYS = 4;
  localparam int unsigned DC   = 16;

  logic            clk = 1'b0;
  logic            nrst;
  logic [KEYS-1:0] key_n;
`ifdef AX301_KEY_IRQ_EN
  logic            irq;
`endif

  minibus_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) sif ();

  ax301_key_input #(
    .KEY_COUNT      (KEYS),
    .DEBOUNCE_CYCLES(DC),
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (32)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    ._sif (sif),
    .key_n(key_n)
`ifdef AX301_KEY_IRQ_EN
    ,
    .irq  (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a level flips once the last DC synchronised samples all disagree with it.
  logic [KEYS-1:0] m_sync1, m_sync2, m_level, m_press, m_release;
  logic [KEYS:0]   m_irq_en;
  logic            m_irq;
  logic [DC-1:0]   m_win [KEYS];
  logic [31:0]     exp_rdata;

  task automatic model_reset();
    m_sync1 = '1; m_sync2 = '1;
    m_level = '0; m_press = '0; m_release = '0;
    m_irq_en = '0; m_irq = 1'b0; exp_rdata = '0;
    for (int k = 0; k < KEYS; k++) m_win[k] = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      8'h00: v[KEYS-1:0] = m_level;
      8'h04: v[KEYS-1:0] = m_press;
      8'h08: v[KEYS-1:0] = m_release;
`ifdef AX301_KEY_IRQ_EN
      8'h0C: v[KEYS:0] = m_irq_en;
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic [KEYS-1:0] ks, set_p, set_r, clr_p, clr_r;
    logic            nxt_irq;
    ks = ~m_sync2;
    m_sync2 = m_sync1;
    m_sync1 = key_n;
    exp_rdata = '0;
    if (sif.req && !sif.we) exp_rdata = model_read(sif.addr);
    nxt_irq = (|(m_press & m_irq_en[KEYS-1:0])) | (m_irq_en[KEYS] & (|m_release));
    set_p = '0; set_r = '0; clr_p = '0; clr_r = '0;
    for (int k = 0; k < KEYS; k++) begin
      m_win[k] = {m_win[k][DC-2:0], ks[k]};
      if (m_win[k] == {DC{~m_level[k]}}) begin
        if (m_level[k]) set_r[k] = 1'b1;
        else            set_p[k] = 1'b1;
        m_level[k] = ~m_level[k];
      end
    end
    if (sif.req && sif.we) begin
      if (sif.addr == 8'h04) clr_p = sif.wdata[KEYS-1:0];
      if (sif.addr == 8'h08) clr_r = sif.wdata[KEYS-1:0];
`ifdef AX301_KEY_IRQ_EN
      if (sif.addr == 8'h0C) m_irq_en = sif.wdata[KEYS:0];
`endif
    end
    m_press   = (m_press & ~clr_p) | set_p;
    m_release = (m_release & ~clr_r) | set_r;
    m_irq     = nxt_irq;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
`ifdef AX301_KEY_IRQ_EN
    check_eq("irq_model", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic bus_op(input bit we, input logic [7:0] a, input logic [31:0] wd,
                        input string tag, output logic [31:0] rd);
    sif.req = 1'b1; sif.we = we; sif.addr = a; sif.wdata = wd;
    tick();
    sif.req = 1'b0; sif.we = 1'b0;
    check_eq({tag, "_ack"}, 32'(sif.ack), 32'd1);
    rd = sif.rdata;
    if (!we) check_eq(tag, sif.rdata, exp_rdata);
  endtask

  task automatic rd(input logic [7:0] a, input string tag, output logic [31:0] v);
    bus_op(1'b0, a, 32'h0, tag, v);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string tag);
    logic [31:0] dummy;
    bus_op(1'b1, a, d, tag, dummy);
  endtask

  logic [31:0] v;
  int          hold [KEYS];

  initial begin
    nrst = 1'b0; key_n = '1;
    sif.req = 1'b0; sif.we = 1'b0; sif.addr = '0; sif.wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // 1. reset state
`ifdef AX301_KEY_IRQ_EN
    check_eq("rst_irq", 32'(irq), 32'd0);
`endif
    rd(8'h00, "rst_level", v);   check_eq("rst_level_c", v, 32'h0);
    rd(8'h04, "rst_press", v);   check_eq("rst_press_c", v, 32'h0);
    rd(8'h08, "rst_release", v); check_eq("rst_release_c", v, 32'h0);

    // 2. qualified press of key 0: read issued at edge N returns the pre-edge value
    key_n[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      rd(8'h00, "t2_level", v);
      if (i == 18) check_eq("t2_level_before", v, 32'h0);
      if (i == 19) check_eq("t2_level_after", v, 32'h1);
    end
    rd(8'h04, "t2_press", v);  check_eq("t2_press_c", v, 32'h1);
    wr(8'h04, 32'h1, "t2_w1c");
    rd(8'h04, "t2_press_clr", v); check_eq("t2_press_clr_c", v, 32'h0);

    // 3. bouncing key 1 never qualifies
    for (int i = 0; i < 100; i++) begin
      if (i % 5 == 0) key_n[1] = ~key_n[1];
      rd(8'h00, "t3_level", v);
    end
    repeat (4) tick();
    rd(8'h00, "t3_level_end", v); check_eq("t3_level_c", v, 32'h1);
    rd(8'h04, "t3_press", v);     check_eq("t3_press_c", v, 32'h0);

    // 4. W1C of PRESS[2] in the very cycle key 2 qualifies
    key_n[2] = 1'b0;
    repeat (17) tick();
    wr(8'h04, 32'h4, "t4_w1c");
    rd(8'h04, "t4_press", v); check_eq("t4_press_c", v, 32'h4);

    // 5. release of key 0, unmapped read, write to read-only LEVEL
    key_n[0] = 1'b1;
    repeat (20) tick();
    rd(8'h08, "t5_release", v); check_eq("t5_release_c", v, 32'h1);
    rd(8'h10, "t5_unmapped", v); check_eq("t5_unmapped_c", v, 32'h0);
    wr(8'h00, 32'hF, "t5_wr_level");
    rd(8'h00, "t5_level", v); check_eq("t5_level_c", v, 32'h4);

`ifdef AX301_KEY_IRQ_EN
    // 6. interrupt path and reset mid-count
    wr(8'h0C, 32'h1, "t6_en");
    key_n[0] = 1'b0;
    repeat (17) tick();
    tick(); check_eq("t6_irq_pre", 32'(irq), 32'd0);
    tick(); check_eq("t6_irq_set", 32'(irq), 32'd1);
    wr(8'h04, 32'h1, "t6_w1c");
    tick(); check_eq("t6_irq_clr", 32'(irq), 32'd0);
    wr(8'h0C, 32'h10, "t6_en_rel");
    tick(); check_eq("t6_irq_rel", 32'(irq), 32'd1);
    key_n[1] = 1'b0;
    repeat (5) tick();
    nrst = 1'b0;
    #1;
    check_eq("t6_irq_rst", 32'(irq), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 nrst = 1'b1;
    rd(8'h00, "t6_level_rst", v); check_eq("t6_level_rst_c", v, 32'h0);
    rd(8'h0C, "t6_en_rst", v);    check_eq("t6_en_rst_c", v, 32'h0);
`endif

    // Random key activity with interleaved bus traffic
    for (int k = 0; k < KEYS; k++) hold[k] = $urandom_range(1, 40);
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      int         op;
      for (int k = 0; k < KEYS; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          key_n[k] = ~key_n[k];
          hold[k]  = $urandom_range(1, 40);
        end
      end
      case ($urandom_range(0, 5))
        0: a = 8'h00;
        1: a = 8'h04;
        2: a = 8'h08;
        3: a = 8'h0C;
        4: a = 8'h10;
        default: a = 8'($urandom_range(0, 255));
      endcase
      op = $urandom_range(0, 9);
      if (op < 5)      rd(a, "rnd_rd", v);
      else if (op < 7) wr(a, $urandom, "rnd_wr");
      else             tick();
    end
    for (int a = 0; a < 16; a += 4) rd(8'(a), "final_rd", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
